ring_interconnect: RTL and testbench

Unidirectional ring network-on-chip connecting NUM_PROC cache/core nodes in the interconnect simulator. Each node injects address-only packets (src, dest, 48-bit memory address); the ring moves them one hop per clock toward node (i+1) mod NUM_PROC and ejects them at the destination node. It sits between the per-core request queues and the reply path, clocked by the divided interconnect clock.

---
 rtl/ring_interconnect.sv | 104 ++++++++++
 tb/tb_ring_interconnect.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ring_interconnect.sv
// Unidirectional ring NoC: one stage register per node, one hop per clock, eject at dest.
// Optional macro RING_LOCAL_BYPASS_EN: dest == node packets are ejected locally in the offer cycle.
module ring_node #(
   parameter int NODE_ID    = 0,
   parameter int NUM_PROC   = 4,
   parameter int ID_SIZE    = 2,
   parameter int DATA_WIDTH = 48,
   parameter int PKT_W      = 2*ID_SIZE + DATA_WIDTH
) (
   input  logic             i_rst,
   input  logic             i_stg_vld,
   input  logic [PKT_W-1:0] i_stg_pkt,
   input  logic             i_ofr_vld,
   input  logic [PKT_W-1:0] i_ofr_pkt,
   output logic             o_lnk_vld,
   output logic [PKT_W-1:0] o_lnk_pkt,
   output logic             o_ej_vld,
   output logic [PKT_W-1:0] o_ej_pkt,
   output logic             o_acc,
   output logic             o_full
);
   localparam logic [ID_SIZE-1:0] MY_ID = ID_SIZE'(NODE_ID);
   localparam logic [ID_SIZE:0]   NP    = (ID_SIZE+1)'(NUM_PROC);

   logic [ID_SIZE-1:0] w_stg_dest, w_ofr_dest;
   logic               w_here, w_thru, w_ofr_ok, w_inj;

   assign w_stg_dest = i_stg_pkt[DATA_WIDTH +: ID_SIZE];
   assign w_ofr_dest = i_ofr_pkt[DATA_WIDTH +: ID_SIZE];
   assign w_here     = i_stg_vld & (w_stg_dest == MY_ID);
   assign w_thru     = i_stg_vld & ~w_here;
   // Out-of-range destinations are accepted but never put on the link.
   assign w_ofr_ok   = ({1'b0, w_ofr_dest} < NP);
   assign o_full     = w_thru | i_rst;

`ifdef RING_LOCAL_BYPASS_EN
   logic w_local, w_bypass;
   assign w_local  = i_ofr_vld & (w_ofr_dest == MY_ID);
   assign w_bypass = w_local & ~w_here & ~i_rst;
   assign o_acc    = w_local ? w_bypass : (i_ofr_vld & ~o_full);
   assign o_ej_vld = w_here | w_bypass;
   assign o_ej_pkt = w_here ? i_stg_pkt : (w_bypass ? i_ofr_pkt : '0);
   assign w_inj    = o_acc & ~w_local & w_ofr_ok;
`else
   assign o_acc    = i_ofr_vld & ~o_full;
   assign o_ej_vld = w_here;
   assign o_ej_pkt = w_here ? i_stg_pkt : '0;
   assign w_inj    = o_acc & w_ofr_ok;
`endif

   assign o_lnk_vld = w_thru | w_inj;
   assign o_lnk_pkt = w_thru ? i_stg_pkt : (w_inj ? i_ofr_pkt : '0);
endmodule

module ring_interconnect #(
   parameter int NUM_PROC   = 4,
   parameter int ID_SIZE    = $clog2(NUM_PROC),
   parameter int DATA_WIDTH = 48,
   parameter int PKT_W      = 2*ID_SIZE + DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic [NUM_PROC-1:0][PKT_W-1:0] packetSendIn,
   input  logic [NUM_PROC-1:0]            packetCoreIn,
   output logic [NUM_PROC-1:0]            recievedOut,
   output logic [NUM_PROC-1:0][PKT_W-1:0] packetRecieved,
   output logic [NUM_PROC-1:0]            recieved,
   output logic [NUM_PROC-1:0]            full
);
   logic [NUM_PROC-1:0]            r_vld;
   logic [NUM_PROC-1:0][PKT_W-1:0] r_pkt;
   logic [NUM_PROC-1:0]            w_lnk_vld;
   logic [NUM_PROC-1:0][PKT_W-1:0] w_lnk_pkt;

   for (genvar i = 0; i < NUM_PROC; i++) begin : g_node
      ring_node #(
         .NODE_ID(i), .NUM_PROC(NUM_PROC), .ID_SIZE(ID_SIZE),
         .DATA_WIDTH(DATA_WIDTH), .PKT_W(PKT_W)
      ) u_node (
         .i_rst     (rst_l),
         .i_stg_vld (r_vld[i]),
         .i_stg_pkt (r_pkt[i]),
         .i_ofr_vld (packetCoreIn[i]),
         .i_ofr_pkt (packetSendIn[i]),
         .o_lnk_vld (w_lnk_vld[i]),
         .o_lnk_pkt (w_lnk_pkt[i]),
         .o_ej_vld  (recieved[i]),
         .o_ej_pkt  (packetRecieved[i]),
         .o_acc     (recievedOut[i]),
         .o_full    (full[i])
      );
   end

   // Link i feeds stage i+1; a rotate-left of the link vector is one hop.
   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         r_vld <= '0;
         r_pkt <= '0;
      end else begin
         r_vld <= {w_lnk_vld[NUM_PROC-2:0], w_lnk_vld[NUM_PROC-1]};
         r_pkt <= {w_lnk_pkt[NUM_PROC-2:0], w_lnk_pkt[NUM_PROC-1]};
      end
   end
endmodule

// File: tb/tb_ring_interconnect.sv
// Randomized + directed bench for ring_interconnect against a latency-formula reference model.
module tb_ring_interconnect;
   localparam int N     = 4;
   localparam int ID    = 2;
   localparam int DW    = 48;
   localparam int PKT_W = 2*ID + DW;

   logic                    clk = 1'b0;
   logic                    rst_l;
   logic [N-1:0][PKT_W-1:0] packetSendIn;
   logic [N-1:0]            packetCoreIn;
   logic [N-1:0]            recievedOut;
   logic [N-1:0][PKT_W-1:0] packetRecieved;
   logic [N-1:0]            recieved;
   logic [N-1:0]            full;

   ring_interconnect #(.NUM_PROC(N), .ID_SIZE(ID), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_l(rst_l), .packetSendIn(packetSendIn), .packetCoreIn(packetCoreIn),
      .recievedOut(recievedOut), .packetRecieved(packetRecieved), .recieved(recieved), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PKT_W-1:0] pkt;
      int               s;
      int               d;
      int               t;
   } fl_t;

   fl_t fl[$];
   int  n_chk = 0, n_fail = 0, cyc = 0, acc_cnt = 0, rcv_cnt = 0;
   logic [N-1:0] last_acc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int hops(int s, int d);
      return (d == s) ? N : ((d - s + N) % N);
   endfunction

   task automatic offer(input int n, input int d, input logic [DW-1:0] a);
      packetCoreIn[n] = 1'b1;
      packetSendIn[n] = {ID'(n), ID'(d), a};
   endtask

   // Check combinational outputs mid-cycle, advance the model, step one clock.
   task automatic cycle();
      logic [N-1:0]            e_full, e_rcv, e_acc;
      logic [N-1:0][PKT_W-1:0] e_pr;
      fl_t keep[$];
      #1;
      e_full = rst_l ? '1 : '0;
      e_rcv  = '0;
      e_pr   = '0;
      foreach (fl[k]) begin
         int a, h, p;
         a = cyc - fl[k].t;
         h = hops(fl[k].s, fl[k].d);
         p = (fl[k].s + a) % N;
         if (a == h) begin
            e_rcv[p] = 1'b1;
            e_pr[p]  = fl[k].pkt;
         end else begin
            e_full[p] = 1'b1;
            keep.push_back(fl[k]);
         end
      end
      for (int i = 0; i < N; i++) begin
         int d;
         d = int'(packetSendIn[i][DW +: ID]);
`ifdef RING_LOCAL_BYPASS_EN
         if (d == i) begin
            e_acc[i] = packetCoreIn[i] & ~e_rcv[i] & ~rst_l;
            if (e_acc[i]) begin
               e_rcv[i] = 1'b1;
               e_pr[i]  = packetSendIn[i];
            end
            continue;
         end
`endif
         e_acc[i] = packetCoreIn[i] & ~e_full[i] & ~rst_l;
         if (e_acc[i]) begin
            fl_t f;
            f.pkt = packetSendIn[i]; f.s = i; f.d = d; f.t = cyc;
            keep.push_back(f);
         end
      end
      chk("full", 64'(full), 64'(e_full));
      chk("recievedOut", 64'(recievedOut), 64'(e_acc));
      chk("recieved", 64'(recieved), 64'(e_rcv));
      for (int i = 0; i < N; i++)
         chk($sformatf("packetRecieved[%0d]", i), 64'(packetRecieved[i]), 64'(e_pr[i]));
      rcv_cnt += $countones(recieved);
      acc_cnt += $countones(e_acc);
      fl = rst_l ? '{} : keep;
      last_acc = e_acc;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      packetCoreIn = packetCoreIn & ~last_acc;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      rst_l        = 1'b1;
      packetCoreIn = '1;
      packetSendIn = '0;
      @(negedge clk);
      cycle();
      cycle();
      rst_l        = 1'b0;
      packetCoreIn = '0;

      // Single packet 0->2
      offer(0, 2, 48'h0000_1234_5678);
      idle(5);
      // Wrap-around and full-loop self destination
      offer(3, 1, 48'hABCD_0000_0003);
      offer(2, 2, 48'h2222_2222_2222);
      idle(6);
      // Contention at node 1
      offer(0, 3, 48'h0000_0000_0303);
      cycle();
      offer(1, 2, 48'h0000_0000_0102);
      idle(6);
      // Simultaneous eject and inject at node 2
      offer(0, 2, 48'h0000_0000_0002);
      cycle();
      cycle();
      offer(2, 0, 48'h0000_0000_0200);
      idle(6);
      // Saturation: every node sends to i+2
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < N; i++)
            if (!packetCoreIn[i]) offer(i, (i + 2) % N, {16'(c), 32'(i)});
         cycle();
      end
      idle(8);
      // Random traffic
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            if (!packetCoreIn[i] && ($urandom_range(1, 0) == 1))
               offer(i, int'($urandom_range(N - 1, 0)), {16'($urandom), $urandom});
         cycle();
      end
      // Reset mid-flight
      packetCoreIn = '0;
      idle(6);
      offer(0, 3, 48'h0000_DEAD_0003);
      offer(1, 0, 48'h0000_DEAD_0100);
      offer(2, 1, 48'h0000_DEAD_0201);
      cycle();
      offer(3, 2, 48'h0000_DEAD_0302);
      rst_l = 1'b1;
      cycle();
      cycle();
      rst_l        = 1'b0;
      packetCoreIn = '0;
      offer(1, 3, 48'h0000_BEEF_0103);
      idle(4);
      // Drain and account for every accepted packet
      packetCoreIn = '0;
      for (int k = 0; k < 50 && fl.size() != 0; k++) cycle();
      chk("drain_inflight", 64'(fl.size()), 64'd0);
      chk("delivered_vs_accepted", 64'(rcv_cnt), 64'(acc_cnt - 3));
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
